stream_demux_1x4_ctrl: RTL and testbench
========================================

Name: stream_demux_1x4_ctrl

Overview:
- Registered, handshaked 1-to-4 stream dispatcher.
- Accepts one W-bit word per valid/ready transfer on a single input, steers it to one of four output channels, and holds it until that channel accepts.
- Keeps a saturating delivered-word counter per channel.
- Sits in front of the 1x4 demux datapath as its sequencing/flow-control layer.

Parameters:
- W, 8, data width of input and each output channel.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block can take the input word this cycle
- in_data  in  W  input word
- in_sel  in  2  destination channel 0..3, sampled with in_data
- y0, y1, y2, y3  out  W each  channel data; zero when that channel is not valid
- y_valid  out  4  bit k = channel k holds a word
- y_ready  in  4  bit k = channel k consumer accepts
- cnt0, cnt1, cnt2, cnt3  out  CNT_W each  delivered-word count per channel
- clr_cnt  in  1  synchronous clear of all counters

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, data_q=0, sel_q=0.
  - y_valid=0, y0..y3=0, cnt0..cnt3=0.
  - in_ready=0 while rst_n=0.
- FSM states:
  - IDLE: staging register empty.
  - BUSY: data_q held for channel sel_q.
- IDLE:
  - in_ready=1.
  - On in_valid: data_q<=in_data, sel_q<=in_sel, go to BUSY.
  - Input-to-output latency is 1 cycle.
- BUSY:
  - y_valid[sel_q]=1, other y_valid bits 0.
  - y[sel_q]=data_q, other yk=0.
  - Output accept = y_ready[sel_q].
  - in_ready = y_ready[sel_q] (combinational pass-through, so back-to-back words sustain 1 word/cycle).
- BUSY with accept and in_valid: load the new word and sel, stay in BUSY (no bubble).
- BUSY with accept and no in_valid: go to IDLE.
- BUSY without accept: hold data_q/sel_q stable. y_valid must not drop and yk must not change until accepted.
- y_ready bits of non-selected channels are ignored.
- in_sel is only sampled on an input transfer (in_valid & in_ready).
- Counters:
  - On each output accept, cnt[sel_q] += 1.
  - Counters saturate at 2^CNT_W-1, no wrap.
- clr_cnt:
  - Zeroes all counters next edge.
  - Takes priority over a same-cycle increment.
  - Does not affect the FSM or data.
- All outputs are registered except in_ready.
- Reset asserted mid-transfer drops the held word; no output is generated after reset release until a new input transfer.

Optional Feature:
- Macro: DEMUX_ROUND_ROBIN_EN.
- Defined:
  - in_sel is ignored.
  - A 2-bit rr_ptr (reset 0) supplies the destination.
  - rr_ptr increments mod 4 on every input transfer; it wraps 3->0.
  - Channel order for consecutive words is 0,1,2,3,0,...
- Not defined: destination comes from in_sel; no rr_ptr register exists.

Decomposition:
- Shared package demux_pkg holds:
  - NUM_CH=4 and SEL_W=2.
  - A typedef for the enum state_t {IDLE, BUSY}.
- One sub-module, sat_cnt (CNT_W-bit saturating counter with inc/clr), instantiated 4 times.

Test Plan:
- Reset then single word: in_data=8'hA5, in_sel=2 → next cycle y_valid=4'b0100, y2=A5, y0/y1/y3=0; with y_ready=4'hF it is accepted, cnt2=1, state returns to IDLE.
- Backpressure: word 8'h3C to ch1 with y_ready[1]=0 for 5 cycles → y1=3C and y_valid[1]=1 stable, in_ready=0; y_ready[1]=1 → in_ready=1 and cnt1=1.
- Streaming: 8 words 0..7 with sel=k%4 and all y_ready=1 → one word per cycle, no bubbles, each count=2.
- Saturation: CNT_W=8, 300 words to ch0 → cnt0=255. clr_cnt asserted together with an accept → cnt0=0.
- Async reset: assert rst_n=0 while BUSY → y_valid=0 and counters=0 immediately, without waiting for a clock edge.
- DEMUX_ROUND_ROBIN_EN: 5 words with in_sel=3 → destinations 0,1,2,3,0.

Source files
------------

// File: rtl/stream_demux_1x4_ctrl_pkg.sv
// demux_pkg: shared constants and types for the 1x4 stream dispatcher.
//   NUM_CH  - number of output channels
//   SEL_W   - width of a channel index
//   state_t - staging-register state (IDLE = empty, BUSY = holding a word)
//   onehot  - channel index to one-hot channel mask
package demux_pkg;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic {IDLE, BUSY} state_t;

   function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] s);
      logic [NUM_CH-1:0] r;
      r    = '0;
      r[s] = 1'b1;
      return r;
   endfunction
endpackage

// File: rtl/stream_demux_1x4_ctrl_sat_cnt.sv
// sat_cnt: CNT_W-bit counter that sticks at all-ones instead of wrapping.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear, wins over inc
//   inc        - count one event
//   cnt        - current count
module sat_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cnt <= '0;
      else if (clr)                cnt <= '0;
      else if (inc && (cnt != '1)) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/stream_demux_1x4_ctrl.sv
// stream_demux_1x4_ctrl: registered valid/ready 1-to-4 dispatcher.
// One word is staged per input transfer and presented on its destination
// channel until that channel's consumer accepts it; per-channel saturating
// counters track delivered words.
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_valid/in_ready - input handshake (in_ready is the only combinational output)
//   in_data, in_sel   - input word and its destination channel
//   y0..y3            - channel data, zero when the channel is not valid
//   y_valid, y_ready  - per-channel output handshake
//   cnt0..cnt3        - delivered-word counts, saturating
//   clr_cnt           - synchronous clear of all counters
// Build option: DEMUX_ROUND_ROBIN_EN - ignore in_sel and dispatch words to
// channels 0,1,2,3,0,... from an internal pointer.
module stream_demux_1x4_ctrl
   import demux_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_data,
   input  logic [SEL_W-1:0]  in_sel,
   output logic [W-1:0]      y0,
   output logic [W-1:0]      y1,
   output logic [W-1:0]      y2,
   output logic [W-1:0]      y3,
   output logic [NUM_CH-1:0] y_valid,
   input  logic [NUM_CH-1:0] y_ready,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1,
   output logic [CNT_W-1:0]  cnt2,
   output logic [CNT_W-1:0]  cnt3,
   input  logic              clr_cnt
);
   state_t                          state;
   logic [W-1:0]                    data_q;
   logic [SEL_W-1:0]                sel_q;
   logic [SEL_W-1:0]                dest;
   logic                            accept;
   logic                            xfer;
   logic [NUM_CH-1:0]               y_valid_q;
   logic [NUM_CH-1:0][W-1:0]        y_q;
   logic [NUM_CH-1:0]               inc;
   logic [NUM_CH-1:0][CNT_W-1:0]    cnt;

   assign accept   = (state == BUSY) && y_ready[sel_q];
   // Ready passes straight through from the held channel so a stream of
   // words moves at one per cycle; forced low while in reset.
   assign in_ready = rst_n && ((state == IDLE) || accept);
   assign xfer     = in_valid && in_ready;

`ifdef DEMUX_ROUND_ROBIN_EN
   logic [SEL_W-1:0] rr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rr_ptr <= '0;
      else if (xfer) rr_ptr <= rr_ptr + 1'b1;
   end

   assign dest = rr_ptr;
`else
   assign dest = in_sel;
`endif

   // Output registers are loaded from the same decisions as the staging
   // register, so y/y_valid always mirror data_q/sel_q without a decode path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         data_q    <= '0;
         sel_q     <= '0;
         y_valid_q <= '0;
         y_q       <= '0;
      end else if (xfer) begin
         state       <= BUSY;
         data_q      <= in_data;
         sel_q       <= dest;
         y_valid_q   <= onehot(dest);
         y_q         <= '0;
         y_q[dest]   <= in_data;
      end else if (accept) begin
         state     <= IDLE;
         y_valid_q <= '0;
         y_q       <= '0;
      end
   end

   genvar k;
   generate
      for (k = 0; k < NUM_CH; k++) begin : g_cnt
         assign inc[k] = accept && (sel_q == SEL_W'(k));
         sat_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_cnt),
            .inc   (inc[k]),
            .cnt   (cnt[k])
         );
      end
   endgenerate

   assign y_valid = y_valid_q;
   assign y0      = y_q[0];
   assign y1      = y_q[1];
   assign y2      = y_q[2];
   assign y3      = y_q[3];
   assign cnt0    = cnt[0];
   assign cnt1    = cnt[1];
   assign cnt2    = cnt[2];
   assign cnt3    = cnt[3];
endmodule

// File: tb/tb_stream_demux_1x4_ctrl.sv
// tb_stream_demux_1x4_ctrl: scoreboard bench for stream_demux_1x4_ctrl.
// Words accepted at the input are queued with their destination; a negedge
// monitor compares outputs, in_ready and counters against that queue and a
// saturating count model. Honours DEMUX_ROUND_ROBIN_EN.
module tb_stream_demux_1x4_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic [7:0] y0, y1, y2, y3;
   logic [3:0] y_valid;
   logic [3:0] y_ready;
   logic [7:0] cnt0, cnt1, cnt2, cnt3;
   logic       clr_cnt;

   stream_demux_1x4_ctrl #(.W(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .y_valid(y_valid), .y_ready(y_ready), .cnt0(cnt0), .cnt1(cnt1),
      .cnt2(cnt2), .cnt3(cnt3), .clr_cnt(clr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] ch;
      logic [7:0] d;
   } item_t;

   item_t      q[$];
   int         m_cnt[4];
   int         m_rr;
   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] y_w[4];
   logic [7:0] cnt_w[4];

   assign y_w[0] = y0;     assign y_w[1] = y1;
   assign y_w[2] = y2;     assign y_w[3] = y3;
   assign cnt_w[0] = cnt0; assign cnt_w[1] = cnt1;
   assign cnt_w[2] = cnt2; assign cnt_w[3] = cnt3;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Scoreboard monitor: observe the cycle's handshakes before the edge.
   logic [3:0] exp_v;
   int         exp_rdy;
   int         exp_y;
   logic [1:0] dst;
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         for (int k = 0; k < 4; k++) m_cnt[k] = 0;
         m_rr = 0;
      end else begin
         for (int k = 0; k < 4; k++) chk($sformatf("cnt%0d", k), cnt_w[k], m_cnt[k]);
         exp_rdy = (q.size() == 0) ? 1 : int'(y_ready[q[0].ch]);
         chk("in_ready", int'(in_ready), exp_rdy);
         exp_v = (q.size() == 0) ? 4'b0000 : (4'b0001 << q[0].ch);
         chk("y_valid", int'(y_valid), int'(exp_v));
         for (int k = 0; k < 4; k++) begin
            exp_y = (q.size() != 0 && q[0].ch == k) ? int'(q[0].d) : 0;
            chk($sformatf("y%0d", k), int'(y_w[k]), exp_y);
         end
         if (q.size() != 0 && y_ready[q[0].ch]) begin
            dst = q[0].ch;
            void'(q.pop_front());
            if (m_cnt[dst] < 255) m_cnt[dst]++;
         end
         if (clr_cnt)
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
         if (in_valid && exp_rdy == 1) begin
`ifdef DEMUX_ROUND_ROBIN_EN
            dst  = m_rr[1:0];
`else
            dst  = in_sel;
`endif
            m_rr = (m_rr + 1) % 4;
            q.push_back('{ch: dst, d: in_data});
         end
      end
   end

   task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] s,
                      input logic [3:0] yr, input logic clr);
      in_valid = v; in_data = d; in_sel = s; y_ready = yr; clr_cnt = clr;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
      y_ready = '0; clr_cnt = 1'b0;
      #3;
      chk("rst_y_valid", int'(y_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_cnt0", int'(cnt0), 0);
      chk("rst_y2", int'(y2), 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(0, 8'h00, 0, 4'hF, 0);

      // single word to channel 2
      cyc(1, 8'hA5, 2, 4'hF, 0);
`ifndef DEMUX_ROUND_ROBIN_EN
      chk("single_y_valid", int'(y_valid), 4);
      chk("single_y2", int'(y2), 8'hA5);
`endif
      cyc(0, 8'h00, 0, 4'hF, 0);
`ifndef DEMUX_ROUND_ROBIN_EN
      chk("single_cnt2", int'(cnt2), 1);
`endif
      chk("single_idle", int'(y_valid), 0);

      // backpressure on channel 1; other ready bits high and ignored
      cyc(1, 8'h3C, 1, 4'hF, 0);
      for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 4'b1101, 0);
`ifndef DEMUX_ROUND_ROBIN_EN
      chk("bp_y1", int'(y1), 8'h3C);
      chk("bp_in_ready", int'(in_ready), 0);
`endif
      cyc(0, 8'h00, 0, 4'hF, 0);
`ifndef DEMUX_ROUND_ROBIN_EN
      chk("bp_cnt1", int'(cnt1), 1);
`endif

      // streaming 8 words, all ready
      cyc(0, 8'h00, 0, 4'hF, 1);
      for (int i = 0; i < 8; i++) cyc(1, 8'(i), 2'(i % 4), 4'hF, 0);
      cyc(0, 8'h00, 0, 4'hF, 0);
      cyc(0, 8'h00, 0, 4'hF, 0);
      chk("stream_cnt0", int'(cnt0), 2);
      chk("stream_cnt1", int'(cnt1), 2);
      chk("stream_cnt2", int'(cnt2), 2);
      chk("stream_cnt3", int'(cnt3), 2);

      // saturation then clear colliding with an accept
      cyc(0, 8'h00, 0, 4'hF, 1);
      for (int i = 0; i < 300; i++) cyc(1, 8'(i), 0, 4'hF, 0);
      cyc(0, 8'h00, 0, 4'hF, 0);
`ifndef DEMUX_ROUND_ROBIN_EN
      chk("sat_cnt0", int'(cnt0), 255);
`endif
      cyc(1, 8'h77, 0, 4'hF, 0);
      cyc(0, 8'h00, 0, 4'hF, 1);
      chk("clr_cnt0", int'(cnt0), 0);
      chk("clr_cnt1", int'(cnt1), 0);

      // async reset while holding a word
      cyc(1, 8'h12, 3, 4'hF, 0);
      cyc(1, 8'h34, 1, 4'h0, 0);
      cyc(0, 8'h00, 0, 4'h0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_y_valid", int'(y_valid), 0);
      chk("arst_cnt_sum", int'(cnt0) + int'(cnt1) + int'(cnt2) + int'(cnt3), 0);
      chk("arst_in_ready", int'(in_ready), 0);
      @(negedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(0, 8'h00, 0, 4'hF, 0);
      cyc(0, 8'h00, 0, 4'hF, 0);
      chk("post_rst_idle", int'(y_valid), 0);

      // destination sequence with in_sel fixed at 3
      for (int i = 0; i < 5; i++) begin
         cyc(1, 8'(8'h50 + i), 3, 4'hF, 0);
`ifdef DEMUX_ROUND_ROBIN_EN
         chk("rr_dest", int'(y_valid), int'(4'b0001 << (i % 4)));
`else
         chk("sel_dest", int'(y_valid), 8);
`endif
      end
      cyc(0, 8'h00, 0, 4'hF, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
             4'($urandom), 1'($urandom_range(0, 63) == 0));
      for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 4'hF, 0);
      chk("drain_empty", int'(y_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
